// File: rtl/regbank_dump_sequencer_pkg.sv
// Shared definitions for the register-bank debug dump path: FSM states and
// word/byte sizing helpers.
package regbank_dump_sequencer_pkg;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StReq  = 3'd1,
    StWait = 3'd2,
    StSend = 3'd3,
    StNext = 3'd4,
    StDone = 3'd5
  } dump_state_e;

  localparam int unsigned NB_DATA_DEF = 32;
  localparam int unsigned NB_BYTE_DEF = 8;

  function automatic int unsigned bytes_per_word(input int unsigned nb_data,
                                                 input int unsigned nb_byte);
    return nb_data / nb_byte;
  endfunction

  // Keep at least one bit so a single-byte word still has a legal counter.
  function automatic int unsigned byte_cnt_width(input int unsigned bpw);
    return (bpw > 1) ? $clog2(bpw) : 1;
  endfunction

  localparam int unsigned BYTES_PER_WORD = bytes_per_word(NB_DATA_DEF, NB_BYTE_DEF);
  localparam int unsigned NB_BYTE_CNT    = byte_cnt_width(BYTES_PER_WORD);

endpackage

// File: rtl/regbank_dump_sequencer_word_serializer.sv
// Word serializer: splits a loaded word into bytes, LSB first, over a
// valid/ready handshake and flags the final byte transfer.
module regbank_dump_sequencer_word_serializer
  import regbank_dump_sequencer_pkg::*;
#(
  parameter int unsigned NB_DATA = NB_DATA_DEF,
  parameter int unsigned NB_BYTE = NB_BYTE_DEF
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_clear,
  input  logic               i_load,
  input  logic [NB_DATA-1:0] i_word,
  input  logic               i_ready,
  output logic               o_valid,
  output logic [NB_BYTE-1:0] o_data,
  output logic               o_last
);

  localparam int unsigned BPW    = bytes_per_word(NB_DATA, NB_BYTE);
  localparam int unsigned NB_CNT = byte_cnt_width(BPW);
  localparam logic [NB_CNT-1:0] LAST_BYTE = NB_CNT'(BPW - 1);

  logic [NB_DATA-1:0] shift_q, shift_d;
  logic [NB_CNT-1:0]  cnt_q, cnt_d;
  logic               valid_q, valid_d;
  logic               xfer;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  // Clear (abort) outranks a transfer happening on the same edge.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    xfer    = valid_q & i_ready;
    o_last  = 1'b0;
    if (i_clear) begin
      shift_d = '0;
      cnt_d   = '0;
      valid_d = 1'b0;
    end else if (i_load) begin
      shift_d = i_word;
      cnt_d   = '0;
      valid_d = 1'b1;
    end else if (xfer) begin
      shift_d = shift_q >> NB_BYTE;
      cnt_d   = cnt_q + 1'b1;
      if (cnt_q == LAST_BYTE) begin
        valid_d = 1'b0;
        o_last  = 1'b1;
      end
    end
  end

  assign o_valid = valid_q;
  assign o_data  = valid_q ? shift_q[NB_BYTE-1:0] : '0;

endmodule

// File: rtl/regbank_dump_sequencer.sv
// Debug dump sequencer: halts the pipeline, reads every bank register in
// order and streams each word out as bytes, then pulses done.
module regbank_dump_sequencer
  import regbank_dump_sequencer_pkg::*;
#(
  parameter int unsigned NB_DATA    = NB_DATA_DEF,
  parameter int unsigned NB_ADDR    = 5,
  parameter int unsigned BANK_DEPTH = 32,
  parameter int unsigned NB_BYTE    = NB_BYTE_DEF
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic [NB_DATA-1:0] i_rb_data,
  input  logic               i_tx_ready,
  output logic               o_rb_read_enable,
  output logic [NB_ADDR-1:0] o_rb_read_address,
  output logic               o_halt,
  output logic               o_tx_valid,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_busy,
  output logic               o_done
);

  localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(BANK_DEPTH - 1);

  dump_state_e        state_q, state_d;
  logic [NB_ADDR-1:0] addr_q, addr_d;
  logic               word_last;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // Abort forces IDLE from anywhere; in IDLE it also masks a same-cycle start.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    if (i_abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_start) begin
            state_d = StReq;
            addr_d  = '0;
          end
        end
        StReq:  state_d = StWait;
        StWait: state_d = StSend;
        StSend: begin
          if (word_last) state_d = StNext;
        end
        StNext: begin
          if (addr_q == LAST_ADDR) begin
            state_d = StDone;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = StReq;
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  regbank_dump_sequencer_word_serializer #(
    .NB_DATA (NB_DATA),
    .NB_BYTE (NB_BYTE)
  ) u_word_serializer (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_clear (i_abort),
    .i_load  (state_q == StWait),
    .i_word  (i_rb_data),
    .i_ready (i_tx_ready),
    .o_valid (o_tx_valid),
    .o_data  (o_tx_data),
    .o_last  (word_last)
  );

  assign o_busy            = (state_q != StIdle);
  assign o_halt            = o_busy;
  assign o_done            = (state_q == StDone);
  assign o_rb_read_enable  = (state_q == StReq) || (state_q == StWait);
  assign o_rb_read_address = o_busy ? addr_q : '0;

endmodule

// File: doc/regbank_dump_sequencer.md
Name: regbank_dump_sequencer

Overview:
- Debug-path block that sits directly downstream of the register bank's debug read port.
- On command from the debug unit, it halts the pipeline and reads every register address 0..BANK_DEPTH-1 in turn.
- Each word is serialized into bytes, least-significant byte first, over a valid/ready byte stream toward the UART TX.
- It signals completion with a one-cycle done pulse.

Parameters:
- NB_DATA, 32, register word width; must be a multiple of 8.
- NB_ADDR, 5, register address width.
- BANK_DEPTH, 32, number of registers dumped; must be ≤ 2^NB_ADDR.
- NB_BYTE, 8, width of the output byte stream.

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  reset; synchronous, active-high; clock is i_clock.
- i_start  in  1  one-cycle dump request from the debug unit.
- i_abort  in  1  cancels a dump in progress.
- i_rb_data  in  NB_DATA  register bank debug read data (bank o_data_a).
- i_tx_ready  in  1  byte sink can accept a byte.
- o_rb_read_enable  out  1  drives the bank's debug read enable.
- o_rb_read_address  out  NB_ADDR  drives the bank's debug read address.
- o_halt  out  1  pipeline halt request; drives the bank's i_enable low while high.
- o_tx_valid  out  1  byte on o_tx_data is valid.
- o_tx_data  out  NB_BYTE  byte to transmit.
- o_busy  out  1  dump in progress (any state other than IDLE).
- o_done  out  1  one-cycle pulse when the dump completes.

Behaviour:
- Reset values:
  - State = IDLE.
  - All outputs 0: o_rb_read_address, o_tx_data, o_tx_valid, o_rb_read_enable, o_halt, o_busy, o_done.
  - Internal address counter, byte counter and shift register cleared.
- States: IDLE, REQ, WAIT, SEND, NEXT, DONE.
- IDLE:
  - i_start=1 → REQ, with address counter = 0.
  - i_start while not IDLE is ignored.
- REQ:
  - o_rb_read_enable=1, o_rb_read_address=addr → WAIT.
  - The bank registers the read, so data is valid during the following cycle.
- WAIT:
  - Read enable and address are held.
  - At the closing edge, i_rb_data is latched into the shift register, byte counter = 0 → SEND.
- SEND:
  - o_tx_valid=1, o_tx_data = shift[NB_BYTE-1:0].
  - A transfer occurs on an edge with o_tx_valid & i_tx_ready. On transfer: shift right by NB_BYTE, byte counter +1.
  - After NB_DATA/NB_BYTE transfers → NEXT, and o_tx_valid drops.
  - o_tx_data must stay stable while o_tx_valid=1 and i_tx_ready=0.
  - o_tx_valid never drops without a transfer, except on abort or reset.
- NEXT:
  - addr == BANK_DEPTH-1 → DONE.
  - Otherwise addr+1 → REQ.
  - The address counter never wraps.
- DONE: o_done=1 for exactly one cycle → IDLE.
- o_halt = o_busy, registered and high in every non-IDLE state.
- Timing with i_tx_ready tied high:
  - 7 cycles per word.
  - o_done asserts in the 225th cycle after the edge that sampled i_start (32 words).
  - Each cycle with i_tx_ready=0 in SEND adds exactly one cycle.
- i_abort:
  - Takes effect in any non-IDLE state at the next edge: → IDLE, all outputs cleared, no o_done pulse.
  - Abort has priority over a simultaneous transfer.
  - i_abort in IDLE has no effect.
  - i_abort and i_start together in IDLE: abort wins, stay IDLE.
- i_reset mid-dump behaves as abort and additionally clears all counters.
- Reset has priority over everything.

Decomposition:
- Shared debug package holds:
  - state encoding localparams (IDLE..DONE);
  - BYTES_PER_WORD = NB_DATA/NB_BYTE;
  - the byte-counter width (clog2 of BYTES_PER_WORD).
- One sub-module, word_serializer, owns the shift register, byte counter and valid/ready handshake.
  - Interface: load + word in; valid/data/ready out; last-byte-sent pulse.
- The FSM and address counter stay in the top module.

Test Plan:
- Bank preloaded with reg0=255, reg1=10, reg2=200, reg3=420, others 0; i_tx_ready=1; pulse i_start.
  - Byte stream begins FF 00 00 00 0A 00 00 00 C8 00 00 00 A4 01 00 00.
  - 128 bytes total.
  - o_done pulses exactly once, 225 cycles after start.
  - o_halt high throughout.
- Backpressure: i_tx_ready toggles 1/0 each cycle.
  - Same 128 bytes.
  - o_tx_data stable whenever valid&!ready.
  - o_done delayed by exactly the number of ready-low cycles spent in SEND.
- i_start re-pulsed at cycle 50 of a dump: ignored; single o_done; byte count 128.
- i_abort during SEND of reg2 byte 1 with ready=0: next cycle o_tx_valid=0, o_busy=0, o_halt=0, no o_done.
  - A new i_start then dumps from reg0.
- i_reset at cycle 100 mid-dump: all outputs 0 next cycle; after release, IDLE until i_start.
- Address sequencing: o_rb_read_address goes 0..31 monotonically.
  - o_rb_read_enable is high only in REQ/WAIT (2 cycles per word).
  - The address never reaches 32 or wraps.
